// File: rtl/rsa_modexp_ctrl_if.sv
// Load/result and modular-multiplier handshake bundle for rsa_modexp_ctrl.
// Latency: none, wires only.
// Backpressure: none; the multiplier paces the controller through mul_start/mul_done.
interface rsa_modexp_ctrl_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  ctrl_load;
    logic [DATA_WIDTH-1:0] ctrl_din;
    logic                  ctrl_busy;
    logic                  ctrl_done;
    logic                  ctrl_err;
    logic [1:0]            ctrl_err_code;
    logic [DATA_WIDTH-1:0] ctrl_c;
    logic                  mul_start;
    logic [DATA_WIDTH-1:0] mul_a;
    logic [DATA_WIDTH-1:0] mul_b;
    logic [DATA_WIDTH-1:0] mul_n;
    logic                  mul_done;
    logic [DATA_WIDTH-1:0] mul_p;

    // Environment side: host loading operands plus the external multiplier.
    modport master (
        output ctrl_load, ctrl_din, mul_done, mul_p,
        input  ctrl_busy, ctrl_done, ctrl_err, ctrl_err_code, ctrl_c,
               mul_start, mul_a, mul_b, mul_n
    );

    // Controller side.
    modport slave (
        input  ctrl_load, ctrl_din, mul_done, mul_p,
        output ctrl_busy, ctrl_done, ctrl_err, ctrl_err_code, ctrl_c,
               mul_start, mul_a, mul_b, mul_n
    );
endinterface

// File: rtl/rsa_modexp_ctrl.sv
// Serially loads M, E (LSW first), N and computes C = M^E mod N by left-to-right square-and-multiply.
// Latency: CHECK + leading-zero NORM steps + per-bit (NEXT + SQR + L [+ MUL + L]) + DONE.
// Backpressure: stalls in SQR_W/MUL_W until mul_done; ctrl_load is ignored while busy.
module rsa_modexp_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int EXP_WIDTH  = 16
) (
    input  logic               ctrl_clk,
    input  logic               ctrl_rst,
    rsa_modexp_ctrl_if.slave   bus
);
    localparam int EXP_WORDS = EXP_WIDTH / DATA_WIDTH;
    localparam int WW        = $clog2(EXP_WORDS + 1);
    localparam int CNT_W     = $clog2(EXP_WIDTH);
    localparam logic [WW-1:0]    LAST_WORD = WW'(EXP_WORDS);
    localparam logic [CNT_W-1:0] CNT_TOP   = CNT_W'(EXP_WIDTH - 1);

    typedef enum logic [3:0] {
        IDLE, LOAD_M, WAIT_M, LOAD_E, WAIT_E, LOAD_N, WAIT_N, CHECK,
        NORM, SQR, SQR_W, MUL, MUL_W, NEXT, DONE, ERROR
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] m_q, n_q, x_q, c_q, mul_a_q, mul_b_q;
    logic [EXP_WIDTH-1:0]  e_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [WW-1:0]         wcnt_q;
    logic                  busy_q, done_q, err_q, mul_start_q;
    logic [1:0]            code_q;

    logic [EXP_WIDTH-1:0]  e_load_d;
    logic [EXP_WIDTH-1:0]  e_shl_d;

    // Exponent words arrive LSW first: each new word enters at the top and older words move down.
    always_comb begin
        e_load_d = (e_q >> DATA_WIDTH) | (EXP_WIDTH'(bus.ctrl_din) << (EXP_WIDTH - DATA_WIDTH));
        e_shl_d  = e_q << 1;
    end

    // Main controller: load sequencing, operand checks and the square-and-multiply loop.
    always_ff @(posedge ctrl_clk) begin
        if (ctrl_rst) begin
            state_q     <= IDLE;
            m_q         <= '0;
            e_q         <= '0;
            n_q         <= '0;
            x_q         <= '0;
            c_q         <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= 2'b00;
            mul_start_q <= 1'b0;
        end else begin
            mul_start_q <= 1'b0;
            case (state_q)
                IDLE: state_q <= LOAD_M;
                LOAD_M: if (bus.ctrl_load) begin
                    m_q     <= bus.ctrl_din;
                    wcnt_q  <= '0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    code_q  <= 2'b00;
                    state_q <= WAIT_M;
                end
                WAIT_M: if (!bus.ctrl_load) state_q <= LOAD_E;
                LOAD_E: if (bus.ctrl_load) begin
                    e_q     <= e_load_d;
                    wcnt_q  <= wcnt_q + 1'b1;
                    state_q <= WAIT_E;
                end
                WAIT_E: if (!bus.ctrl_load) state_q <= (wcnt_q == LAST_WORD) ? LOAD_N : LOAD_E;
                LOAD_N: if (bus.ctrl_load) begin
                    n_q     <= bus.ctrl_din;
                    state_q <= WAIT_N;
                end
                WAIT_N: if (!bus.ctrl_load) begin
                    busy_q  <= 1'b1;
                    state_q <= CHECK;
                end
                CHECK: begin
                    if (n_q == '0) begin
                        code_q  <= 2'b01;
                        state_q <= ERROR;
                    end else if (m_q >= n_q) begin
                        code_q  <= 2'b10;
                        state_q <= ERROR;
                    end else if (e_q == '0) begin
                        // x^0 is 1, except that everything is 0 modulo 1.
                        x_q     <= (n_q == DATA_WIDTH'(1)) ? '0 : DATA_WIDTH'(1);
                        state_q <= DONE;
                    end else begin
                        x_q     <= m_q;
                        cnt_q   <= CNT_TOP;
                        state_q <= NORM;
                    end
                end
                // Skip leading zeros; the leading one is consumed here since x already equals M.
                NORM: begin
                    e_q <= e_shl_d;
                    if (!e_q[EXP_WIDTH-1]) cnt_q   <= cnt_q - 1'b1;
                    else                   state_q <= NEXT;
                end
                NEXT: begin
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= cnt_q - 1'b1;
                        state_q <= SQR;
                    end
                end
                SQR: begin
                    mul_start_q <= 1'b1;
                    mul_a_q     <= x_q;
                    mul_b_q     <= x_q;
                    state_q     <= SQR_W;
                end
                // A done coincident with our own start pulse belongs to nothing we issued.
                SQR_W: if (bus.mul_done && !mul_start_q) begin
                    x_q     <= bus.mul_p;
                    e_q     <= e_shl_d;
                    state_q <= e_q[EXP_WIDTH-1] ? MUL : NEXT;
                end
                MUL: begin
                    mul_start_q <= 1'b1;
                    mul_a_q     <= x_q;
                    mul_b_q     <= m_q;
                    state_q     <= MUL_W;
                end
                MUL_W: if (bus.mul_done && !mul_start_q) begin
                    x_q     <= bus.mul_p;
                    state_q <= NEXT;
                end
                DONE: begin
                    c_q     <= x_q;
                    done_q  <= 1'b1;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= LOAD_M;
                end
                ERROR: begin
                    c_q     <= '1;
                    done_q  <= 1'b1;
                    err_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= LOAD_M;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ctrl_busy     = busy_q;
    assign bus.ctrl_done     = done_q;
    assign bus.ctrl_err      = err_q;
    assign bus.ctrl_err_code = code_q;
    assign bus.ctrl_c        = c_q;
    assign bus.mul_start     = mul_start_q;
    assign bus.mul_a         = mul_a_q;
    assign bus.mul_b         = mul_b_q;
    assign bus.mul_n         = n_q;
endmodule

// File: doc/rsa_modexp_ctrl.md
# rsa_modexp_ctrl

Parametrised successor controller for the RSA datapath. It serially loads message M, exponent E (one or more words) and modulus N over the shared `ctrl_din` bus, then computes C = M^E mod N by left-to-right square-and-multiply. Each modular product is delegated to an external modular multiplier through a start/done handshake. It adds input validation, error codes and a busy flag.

## Interface
- `DATA_WIDTH`, 16: width of M, N, C and of the load bus.
- `EXP_WIDTH`, 16: exponent width. Must be a nonzero multiple of `DATA_WIDTH`. EXP_WORDS = EXP_WIDTH/DATA_WIDTH.
- `ctrl_clk` in 1: single clock, rising edge.
- `ctrl_rst` in 1: reset, synchronous, active-high.
- `ctrl_load` in 1: load strobe; a word is captured on its rising level, see Timing.
- `ctrl_din` in DATA_WIDTH: load data.
- `ctrl_busy` out 1: high while checking or computing.
- `ctrl_done` out 1: result/error valid.
- `ctrl_err` out 1: error flag.
- `ctrl_err_code` out 2: 00 none, 01 N==0, 10 M>=N.
- `ctrl_c` out DATA_WIDTH: result.
- `mul_start` out 1: one-cycle request to the multiplier.
- `mul_a`, `mul_b`, `mul_n` out DATA_WIDTH each: multiplier operands and modulus.
- `mul_done` in 1: one-cycle completion pulse from the multiplier.
- `mul_p` in DATA_WIDTH: product (a*b mod n), valid with `mul_done`.

## Operation
- Load sequence: M, then E words least-significant first (EXP_WORDS words), then N. Each word is captured in a LOAD_x state when `ctrl_load`=1. The FSM then waits in WAIT_x until `ctrl_load`=0.
- States: IDLE, LOAD_M, WAIT_M, LOAD_E, WAIT_E, LOAD_N, WAIT_N, CHECK, NORM, SQR, SQR_W, MUL, MUL_W, NEXT, DONE, ERROR.
- Sequencing of E words: WAIT_E returns to LOAD_E until the word counter reaches EXP_WORDS, then goes to LOAD_N.
- IDLE → LOAD_M unconditionally. Capturing M clears `ctrl_done`, `ctrl_err` and `ctrl_err_code`.
- CHECK (busy=1), in priority order:
  - N==0 → ERROR, code 01.
  - M>=N → ERROR, code 10.
  - E==0 → DONE with x = (N==1) ? 0 : 1.
  - Otherwise x=M, bit counter = EXP_WIDTH-1, → NORM.
- NORM: one step per cycle. If e[MSB]==0, shift e left by 1 and decrement the counter. If e[MSB]==1, shift once more (consuming the leading 1) and go to NEXT.
- NEXT:
  - Counter==0 → DONE.
  - Else decrement the counter → SQR.
- SQR: pulse `mul_start` with a=b=x → SQR_W. SQR_W waits for `mul_done`, then x=mul_p.
  - If the consumed bit e[MSB]==1 → MUL.
  - Else → NEXT.
  - In both cases e shifts left by 1.
- MUL: pulse `mul_start` with a=x, b=M → MUL_W. MUL_W waits for `mul_done`, then x=mul_p → NEXT.
- DONE: c=x, done=1, err=0, busy=0 → LOAD_M.
- ERROR: c = all ones, done=1, err=1, busy=0 → LOAD_M.
- `mul_n`=N always. `mul_a`/`mul_b` hold stable from the `mul_start` cycle until `mul_done`.
- Arithmetic: the bit counter is clog2(EXP_WIDTH) bits. The shift register is EXP_WIDTH bits; zeros are shifted in.

## Timing
- Reset values:
  - State = IDLE.
  - `ctrl_busy`, `ctrl_done`, `ctrl_err`, `mul_start` = 0.
  - `ctrl_err_code` = 00.
  - `ctrl_c`, `mul_a`, `mul_b` = 0.
  - M, E, N and x registers are cleared.
- `ctrl_rst` overrides all other inputs on the same edge, including mid-load and mid-multiply. A `mul_done` arriving after reset is ignored.
- `ctrl_load` is ignored while busy and in CHECK..DONE/ERROR. Holding `ctrl_load` high captures exactly one word.
- `mul_done` is ignored outside SQR_W/MUL_W. A `mul_done` arriving in the same cycle as `mul_start` is not accepted; the earliest valid `mul_done` is the cycle after.
- `ctrl_done`/`ctrl_c`/`ctrl_err` hold their values until the next M capture.
- Latency from WAIT_N exit (with `ctrl_load`=0) to `ctrl_done`=1, with L = multiplier latency:
  - E==0 or error: 3 cycles.
  - Otherwise: 1 (CHECK) + NORM steps + per-bit costs.
  - Per-bit cost: NEXT 1 + SQR 1 + L, plus MUL 1 + L when the bit is 1.
  - Final NEXT → DONE → output.
- Exactly floor(log2 E) squares plus (popcount(E)-1) multiplies are issued.

## Test plan
- M=4, E=13, N=497, multiplier model L=3: `ctrl_c`=445, err=0. Exactly 3 squares and 2 multiplies issued; busy high throughout the computation.
- M=5, E=1, N=7: `ctrl_c`=5, no `mul_start` issued. Then M=3, E=0, N=7: `ctrl_c`=1. Then M=0, E=0, N=1: `ctrl_c`=0.
- M=3, E=5, N=0: err=1, code 01, `ctrl_c`=16'hFFFF, done=1, no multiplies. Then M=9, E=2, N=7: code 10.
- EXP_WIDTH=32, DATA_WIDTH=16, M=2, E=0x0001_0000, N=65521: checks two-word E ordering; result equals the model value, 16 squares issued.
- Assert `ctrl_rst` during MUL_W, then drive a stray `mul_done`: all outputs return to reset values and the FSM returns to IDLE. A fresh load then computes correctly.
- Hold `ctrl_load` high for 5 cycles per word; pulse `ctrl_load` during busy: only 3 words captured, the pulses during busy are ignored, and the result is unchanged.
